// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// Module  : fetch_stage_pkg
// Brief   : Shared CPU constants and encodings used by the fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  localparam logic [31:0] C_NOP      = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_BR   = 2'b01,
    PCSRC_JALR = 2'b10,
    PCSRC_RSVD = 2'b11
  } pc_src_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_pc_next_sel.sv
// ============================================================================
// Module  : pc_next_sel
// Brief   : Combinational next-PC logic: sequential add, redirect target, select.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel
  import fetch_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [1:0]            i_pc_src,
  input  logic [DATA_WIDTH-1:0] i_pc_e,
  input  logic [DATA_WIDTH-1:0] i_imm_ext_e,
  input  logic [DATA_WIDTH-1:0] i_alu_result_e,
  output logic [DATA_WIDTH-1:0] o_pc_plus4,
  output logic [DATA_WIDTH-1:0] o_target,
  output logic                  o_redirect
);

  pc_src_t w_src;

  always_comb begin
    w_src      = pc_src_t'(i_pc_src);
    o_pc_plus4 = i_pc + DATA_WIDTH'(4);
    o_target   = o_pc_plus4;
    o_redirect = 1'b0;
    // Reserved encoding falls through to sequential.
    case (w_src)
      PCSRC_BR: begin
        o_target   = i_pc_e + i_imm_ext_e;
        o_redirect = 1'b1;
      end
      PCSRC_JALR: begin
        o_target   = {i_alu_result_e[DATA_WIDTH-1:1], 1'b0};
        o_redirect = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Brief   : PC register, instruction fetch and fetch/decode pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(C_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [1:0]            pc_src,
  input  logic [DATA_WIDTH-1:0] pc_e,
  input  logic [DATA_WIDTH-1:0] imm_ext_e,
  input  logic [DATA_WIDTH-1:0] alu_result_e,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_valid,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d
);

  localparam logic [DATA_WIDTH-1:0] C_NOP_W = DATA_WIDTH'(C_NOP);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr_d;
  logic [DATA_WIDTH-1:0] r_pc_d;
  logic [DATA_WIDTH-1:0] r_pc_plus4_d;
  logic                  r_valid_d;

  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_redirect;

  pc_next_sel #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pc_next_sel (
    .i_pc           (r_pc),
    .i_pc_src       (pc_src),
    .i_pc_e         (pc_e),
    .i_imm_ext_e    (imm_ext_e),
    .i_alu_result_e (alu_result_e),
    .o_pc_plus4     (w_pc_plus4),
    .o_target       (w_target),
    .o_redirect     (w_redirect)
  );

  // Redirect beats stall so a taken branch is never lost behind a hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (!stall && imem_valid) begin
      r_pc <= w_pc_plus4;
    end
  end

  // Bubbles keep pc_d/pc_plus4_d so the last real PC stays observable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_d    <= C_NOP_W;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (flush || w_redirect) begin
      r_instr_d <= C_NOP_W;
      r_valid_d <= 1'b0;
    end else if (stall) begin
      r_instr_d <= r_instr_d;
    end else if (imem_valid) begin
      r_instr_d    <= imem_rdata;
      r_pc_d       <= r_pc;
      r_pc_plus4_d <= w_pc_plus4;
      r_valid_d    <= 1'b1;
    end else begin
      r_instr_d <= C_NOP_W;
      r_valid_d <= 1'b0;
    end
  end

  assign imem_addr  = r_pc;
  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign valid_d    = r_valid_d;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Directed-vector scoreboard bench for fetch_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, imem_valid;
  logic [1:0]  pc_src;
  logic [31:0] pc_e, imm_ext_e, alu_result_e, imem_rdata;
  logic [31:0] imem_addr, instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .pc_src       (pc_src),
    .pc_e         (pc_e),
    .imm_ext_e    (imm_ext_e),
    .alu_result_e (alu_result_e),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc_plus4_d   (pc_plus4_d),
    .valid_d      (valid_d)
  );

  // Apply one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input string nm, input logic r, input logic st, input logic fl,
                      input logic [1:0] ps, input logic [31:0] pe, input logic [31:0] imm,
                      input logic [31:0] alu, input logic iv, input logic [31:0] rd,
                      input logic [31:0] e_addr, input logic [31:0] e_instr,
                      input logic [31:0] e_pc, input logic [31:0] e_pc4, input logic e_v);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; flush = fl; pc_src = ps;
    pc_e = pe; imm_ext_e = imm; alu_result_e = alu;
    imem_valid = iv; imem_rdata = rd;
    e.name = nm; e.addr = e_addr; e.instr = e_instr; e.pc = e_pc; e.pc4 = e_pc4; e.v = e_v;
    q.push_back(e);
  endtask

  // Monitor: one observation per edge, popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (imem_addr !== e.addr || instr_d !== e.instr || pc_d !== e.pc ||
            pc_plus4_d !== e.pc4 || valid_d !== e.v) begin
          $display("FAIL %s: got addr=%h instr=%h pc=%h pc4=%h v=%b, want addr=%h instr=%h pc=%h pc4=%h v=%b",
                   e.name, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d,
                   e.addr, e.instr, e.pc, e.pc4, e.v);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
    pc_e = '0; imm_ext_e = '0; alu_result_e = '0; imem_valid = 1'b0; imem_rdata = '0;

    //    name          rst st fl src   pc_e          imm           alu           iv rdata          addr          instr         pc            pc4           v
    step("reset",       1, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 32'h0,        32'h0,        NOP,          32'h0,        32'h0,        0);
    step("seq0",        0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00100093, 32'h4,        32'h00100093, 32'h0,        32'h4,        1);
    step("seq1",        0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00200113, 32'h8,        32'h00200113, 32'h4,        32'h8,        1);
    step("stall1",      0, 1, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00300193, 32'h8,        32'h00200113, 32'h4,        32'h8,        1);
    step("stall2",      0, 1, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00300193, 32'h8,        32'h00200113, 32'h4,        32'h8,        1);
    step("resume",      0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00300193, 32'hC,        32'h00300193, 32'h8,        32'hC,        1);
    step("wait1",       0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 32'hDEADBEEF, 32'hC,        NOP,          32'h8,        32'hC,        0);
    step("wait2",       0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 32'hDEADBEEF, 32'hC,        NOP,          32'h8,        32'hC,        0);
    step("wait3",       0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 32'hDEADBEEF, 32'hC,        NOP,          32'h8,        32'hC,        0);
    step("wait_resume", 0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00400213, 32'h10,       32'h00400213, 32'hC,        32'h10,       1);
    step("branch",      0, 0, 0, 2'b01, 32'h10,       32'hFFFFFFF8, 32'h0,        1, 32'h12345678, 32'h8,        NOP,          32'hC,        32'h10,       0);
    step("post_branch", 0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00500293, 32'hC,        32'h00500293, 32'h8,        32'hC,        1);
    step("jalr",        0, 0, 0, 2'b10, 32'h0,        32'h0,        32'h00000103, 1, 32'h12345678, 32'h102,      NOP,          32'h8,        32'hC,        0);
    step("misaligned",  0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00600313, 32'h106,      32'h00600313, 32'h102,      32'h106,      1);
    step("stall_flush", 0, 1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h12345678, 32'h106,      NOP,          32'h102,      32'h106,      0);
    step("br_stall",    0, 1, 0, 2'b01, 32'hFFFFFFF0, 32'h0000000C, 32'h0,        1, 32'h12345678, 32'hFFFFFFFC, NOP,          32'h102,      32'h106,      0);
    step("wrap",        0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00700393, 32'h0,        32'h00700393, 32'hFFFFFFFC, 32'h0,        1);
    step("post_wrap",   0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00800413, 32'h4,        32'h00800413, 32'h0,        32'h4,        1);
    step("rst_mid",     1, 1, 1, 2'b01, 32'h40,       32'h0,        32'h0,        1, 32'h12345678, 32'h0,        NOP,          32'h0,        32'h0,        0);
    step("refetch",     0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 32'h00100093, 32'h4,        32'h00100093, 32'h0,        32'h4,        1);
    step("rsvd_seq",    0, 0, 0, 2'b11, 32'h80,       32'h80,       32'h80,       1, 32'h00200113, 32'h8,        32'h00200113, 32'h4,        32'h8,        1);

    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete, checks=%0d passed=%0d", n_checks, n_pass);
      $fatal(1);
    end
  end

endmodule

`default_nettype wire
